alert_scheduler: RTL

Shares the single car-panel alarm LED between three fault requesters: emergency stop, overload and door fault. Each request is latched until acknowledged. A fixed-priority arbiter picks the winner at frame boundaries, and a unit-timed sequencer plays that source's Morse-style pattern. The block sits between the elevator FSM fault outputs and the panel LED, and supersedes the free-running blink enable.

---
 rtl/alert_pkg.sv | 49 ++++
 rtl/alert_scheduler_if.sv | 19 +
 rtl/unit_ticker.sv | 27 ++
 rtl/alert_scheduler.sv | 104 ++++++++++
 4 files changed

// File: rtl/alert_pkg.sv
// alert_pkg: shared types, source indices, Morse-style patterns and helpers
// for the alarm LED scheduler.
//   state_t   - sequencer state {IDLE, PLAY}
//   SRC_*     - requester indices; SRC_NONE marks "nothing playing"
//   PAT_*     - left-aligned (MSB = first unit) patterns incl. 7-unit frame gap
//   PAT_LEN   - pattern length in units, indexed by source
package alert_pkg;
  localparam int NUM_SRC = 3;
  localparam int PAT_W   = 34;
  localparam int SLOT_W  = 6;

  typedef enum logic {IDLE, PLAY} state_t;

  localparam logic [1:0] SRC_ESTOP = 2'd0;
  localparam logic [1:0] SRC_OVLD  = 2'd1;
  localparam logic [1:0] SRC_DOOR  = 2'd2;
  localparam logic [1:0] SRC_NONE  = 2'd3;

  localparam logic [PAT_W-1:0] PAT_SOS  = 34'b1010100011101110111000101010000000;
  localparam logic [PAT_W-1:0] PAT_OVLD = {14'b11101110000000, 20'b0};
  localparam logic [PAT_W-1:0] PAT_DOOR = {8'b10000000, 26'b0};

  localparam logic [SLOT_W-1:0] PAT_LEN [NUM_SRC] = '{6'd34, 6'd14, 6'd8};

  function automatic logic [SLOT_W-1:0] pat_len(input logic [1:0] s);
    pat_len = (s == SRC_NONE) ? '0 : PAT_LEN[s];
  endfunction

  // Bit of source s's pattern for a given slot; slots past the end read 0.
  function automatic logic pat_bit(input logic [1:0] s, input logic [SLOT_W-1:0] slot);
    logic [PAT_W-1:0]  p;
    logic [SLOT_W-1:0] idx;
    case (s)
      SRC_ESTOP: p = PAT_SOS;
      SRC_OVLD:  p = PAT_OVLD;
      default:   p = PAT_DOOR;
    endcase
    idx = SLOT_W'(PAT_W - 1) - slot;
    pat_bit = (slot < SLOT_W'(PAT_W)) ? p[idx] : 1'b0;
  endfunction

  // Fixed priority: lowest index wins.
  function automatic logic [1:0] arb_pick(input logic [NUM_SRC-1:0] p);
    if (p[0])      arb_pick = SRC_ESTOP;
    else if (p[1]) arb_pick = SRC_OVLD;
    else if (p[2]) arb_pick = SRC_DOOR;
    else           arb_pick = SRC_NONE;
  endfunction
endpackage

// File: rtl/alert_scheduler_if.sv
// alert_scheduler_if: requester/panel side bundle of the alarm scheduler.
//   req[2:0] - level fault requests (bit0 e-stop ... bit2 door)
//   ack      - one-cycle debounced panel acknowledge
//   led      - alarm LED drive
//   active   - pattern playing
//   src      - source being played, SRC_NONE when idle
//   pending  - latched request flags
interface alert_scheduler_if;
  import alert_pkg::*;
  logic [NUM_SRC-1:0] req;
  logic               ack;
  logic               led;
  logic               active;
  logic [1:0]         src;
  logic [NUM_SRC-1:0] pending;

  modport master (output req, ack, input led, active, src, pending);
  modport slave  (input req, ack, output led, active, src, pending);
endinterface

// File: rtl/unit_ticker.sv
// unit_ticker: Morse unit timebase.
//   clk, rst_n - clock, async active-low reset
//   run        - count enable; counter held at 0 while low
//   strobe     - one-cycle pulse in the last cycle of every unit
module unit_ticker #(
  parameter int UNIT_TICKS = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic strobe
);
  localparam int CW = $clog2(UNIT_TICKS);
  localparam logic [CW-1:0] LAST = CW'(UNIT_TICKS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (!run)        cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  // Combinational so the slot advances on the edge that ends the unit.
  assign strobe = run && (cnt == LAST);
endmodule

// File: rtl/alert_scheduler.sv
// alert_scheduler: shares the panel alarm LED between e-stop, overload and
// door-fault requesters. Requests latch until acked; a fixed-priority pick
// happens only at frame boundaries, then the winner's pattern is played one
// bit per unit.
//   clk, rst_n - clock, async active-low reset
//   bus        - alert_scheduler_if.slave (req, ack in; led, active, src,
//                pending out, all outputs registered)
module alert_scheduler
  import alert_pkg::*;
#(
  parameter int UNIT_TICKS = 25_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  alert_scheduler_if.slave  bus
);
  state_t             state, state_nxt;
  logic [1:0]         src_q, src_nxt;
  logic [SLOT_W-1:0]  slot_q, slot_nxt;
  logic               led_q, led_nxt;
  logic               act_q, act_nxt;
  logic [NUM_SRC-1:0] pend_q, pend_nxt;
  logic               run, strobe;
  logic               ack_clr, frame_end;
  logic [NUM_SRC-1:0] clr_mask;
  logic [1:0]         pick;

  assign run = (state == PLAY);

  unit_ticker #(.UNIT_TICKS(UNIT_TICKS)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .strobe (strobe)
  );

  // Ack only retires the playing source, and only once its request has dropped.
  assign ack_clr   = bus.ack && (state == PLAY) && !bus.req[src_q];
  assign clr_mask  = ack_clr ? (NUM_SRC'(1) << src_q) : '0;
  assign frame_end = strobe && (slot_q == pat_len(src_q) - 1'b1);
  assign pick      = arb_pick(pend_q);

  always_comb begin
    state_nxt = state;
    src_nxt   = src_q;
    slot_nxt  = slot_q;
    led_nxt   = led_q;
    act_nxt   = act_q;
    pend_nxt  = (pend_q | bus.req) & ~clr_mask;
    case (state)
      IDLE: begin
        if (pend_q != '0) begin
          state_nxt = PLAY;
          src_nxt   = pick;
          slot_nxt  = '0;
          led_nxt   = pat_bit(pick, '0);
          act_nxt   = 1'b1;
        end
      end
      PLAY: begin
        // Ack beats frame end: a retired source must not restart.
        if (ack_clr || (frame_end && pend_q == '0)) begin
          state_nxt = IDLE;
          src_nxt   = SRC_NONE;
          slot_nxt  = '0;
          led_nxt   = 1'b0;
          act_nxt   = 1'b0;
        end else if (frame_end) begin
          // Back-to-back frames: re-arbitrate in the same edge.
          src_nxt  = pick;
          slot_nxt = '0;
          led_nxt  = pat_bit(pick, '0);
        end else if (strobe) begin
          slot_nxt = slot_q + 1'b1;
          led_nxt  = pat_bit(src_q, slot_q + 1'b1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      src_q  <= SRC_NONE;
      slot_q <= '0;
      led_q  <= 1'b0;
      act_q  <= 1'b0;
      pend_q <= '0;
    end else begin
      state  <= state_nxt;
      src_q  <= src_nxt;
      slot_q <= slot_nxt;
      led_q  <= led_nxt;
      act_q  <= act_nxt;
      pend_q <= pend_nxt;
    end
  end

  assign bus.led     = led_q;
  assign bus.active  = act_q;
  assign bus.src     = src_q;
  assign bus.pending = pend_q;
endmodule
